// File: rtl/simple_req_ack_responder.sv
// rtl/simple_req_ack_responder.sv - 4-phase req/ack responder with programmable ack delay
// Counts completed handshakes and flags requests withdrawn before acknowledge.
module simple_req_ack_responder #(
    parameter int DELAY_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req,
    output logic               ack,
    input  logic               enable,
    input  logic [DELAY_W-1:0] cfg_delay,
    output logic               busy,
    output logic [CNT_W-1:0]   txn_count,
    output logic               err_drop
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [DELAY_W-1:0] DELAY_ONE = DELAY_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

    state_t             state;
    state_t             state_nxt;
    logic [DELAY_W-1:0] delay_cnt;
    logic [DELAY_W-1:0] delay_cnt_nxt;
    logic               ack_nxt;
    logic               err_drop_nxt;
    logic [CNT_W-1:0]   txn_count_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            delay_cnt <= '0;
            ack       <= 1'b0;
            err_drop  <= 1'b0;
            txn_count <= '0;
        end else begin
            state     <= state_nxt;
            delay_cnt <= delay_cnt_nxt;
            ack       <= ack_nxt;
            err_drop  <= err_drop_nxt;
            txn_count <= txn_count_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        delay_cnt_nxt = delay_cnt;
        ack_nxt       = ack;
        err_drop_nxt  = 1'b0;
        txn_count_nxt = txn_count;
        case (state)
            ST_IDLE: begin
                ack_nxt = 1'b0;
                if (enable && req) begin
                    state_nxt     = ST_WAIT;
                    delay_cnt_nxt = cfg_delay;
                end
            end
            ST_WAIT: begin
                // enable is deliberately ignored once a transaction is under way
                if (!req) begin
                    state_nxt     = ST_IDLE;
                    delay_cnt_nxt = '0;
                    err_drop_nxt  = 1'b1;
                end else if (delay_cnt == '0) begin
                    state_nxt = ST_ACK;
                    ack_nxt   = 1'b1;
                end else begin
                    delay_cnt_nxt = delay_cnt - DELAY_ONE;
                end
            end
            ST_ACK: begin
                if (!req) begin
                    state_nxt     = ST_IDLE;
                    ack_nxt       = 1'b0;
                    txn_count_nxt = txn_count + CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                ack_nxt   = 1'b0;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_simple_req_ack_responder.sv
// tb/tb_simple_req_ack_responder.sv - randomized self-checking bench for simple_req_ack_responder
module tb_simple_req_ack_responder;

    localparam int DELAY_W = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MOD = 1 << CNT_W;

    logic               clock = 1'b0;
    logic               reset;
    logic               req;
    logic               ack;
    logic               enable;
    logic [DELAY_W-1:0] cfg_delay;
    logic               busy;
    logic [CNT_W-1:0]   txn_count;
    logic               err_drop;

    int n_checks = 0;
    int n_fail   = 0;

    // transaction-level reference: a request has an absolute ack deadline edge
    int edge_no    = 0;
    bit m_active   = 0;
    bit m_acked    = 0;
    bit m_drop     = 0;
    int m_deadline = 0;
    int m_count    = 0;

    simple_req_ack_responder #(.DELAY_W(DELAY_W), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .ack       (ack),
        .enable    (enable),
        .cfg_delay (cfg_delay),
        .busy      (busy),
        .txn_count (txn_count),
        .err_drop  (err_drop)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_acked  = 0;
        m_drop   = 0;
        m_count  = 0;
    endtask

    task automatic model_edge();
        edge_no++;
        m_drop = 0;
        if (reset) begin
            model_reset();
        end else if (!m_active) begin
            if (enable && req) begin
                m_active   = 1;
                m_acked    = 0;
                m_deadline = edge_no + 1 + int'(cfg_delay);
            end
        end else if (!m_acked) begin
            if (!req) begin
                m_active = 0;
                m_drop   = 1;
            end else if (edge_no == m_deadline) begin
                m_acked = 1;
            end
        end else if (!req) begin
            m_active = 0;
            m_acked  = 0;
            m_count  = (m_count + 1) % CNT_MOD;
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_eq({tag, "/ack"}, 32'(ack), 32'(m_acked));
        check_eq({tag, "/busy"}, 32'(busy), 32'(m_active));
        check_eq({tag, "/err_drop"}, 32'(err_drop), 32'(m_drop));
        check_eq({tag, "/txn_count"}, 32'(txn_count), 32'(m_count));
    endtask

    // asserts reset between edges and verifies outputs clear before any clock edge
    task automatic do_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        check_eq({tag, "/rst_ack"}, 32'(ack), 0);
        check_eq({tag, "/rst_busy"}, 32'(busy), 0);
        check_eq({tag, "/rst_err"}, 32'(err_drop), 0);
        check_eq({tag, "/rst_cnt"}, 32'(txn_count), 0);
        model_reset();
        tick({tag, "/in_rst"});
        #2 reset = 1'b0;
    endtask

    initial begin : stim
        int first_ack;
        reset     = 1'b1;
        req       = 1'b0;
        enable    = 1'b0;
        cfg_delay = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_eq("por_ack", 32'(ack), 0);
        check_eq("por_busy", 32'(busy), 0);
        check_eq("por_cnt", 32'(txn_count), 0);
        check_eq("por_err", 32'(err_drop), 0);
        #2 reset = 1'b0;

        // zero-delay handshake: ack one edge after accept, counted when req drops
        enable = 1'b1;
        tick("idle");
        req = 1'b1;
        tick("d0_accept");
        check_eq("d0_busy_edge", 32'(busy), 1);
        tick("d0_ack");
        check_eq("d0_ack_edge", 32'(ack), 1);
        repeat (7) tick("d0_hold");
        req = 1'b0;
        tick("d0_release");
        check_eq("d0_count", 32'(txn_count), 1);

        // cfg_delay change after capture must not shorten the wait
        cfg_delay = 4'd5;
        req       = 1'b1;
        tick("d5_accept");
        first_ack = -1;
        for (int i = 1; i <= 10; i++) begin
            if (i == 2) cfg_delay = 4'd0;
            tick("d5_wait");
            if (ack && first_ack < 0) first_ack = i;
        end
        check_eq("d5_latency", 32'(first_ack), 6);
        req = 1'b0;
        tick("d5_release");

        // withdrawn request
        cfg_delay = 4'd3;
        req       = 1'b1;
        tick("drop_accept");
        tick("drop_wait");
        req = 1'b0;
        tick("drop_edge");
        check_eq("drop_pulse", 32'(err_drop), 1);
        check_eq("drop_busy", 32'(busy), 0);
        tick("drop_after");
        check_eq("drop_pulse_end", 32'(err_drop), 0);

        // enable low blocks new requests; raising it starts the handshake next edge
        enable = 1'b0;
        req    = 1'b1;
        repeat (20) tick("disabled");
        enable = 1'b1;
        tick("enable_start");
        check_eq("enable_busy", 32'(busy), 1);
        enable = 1'b0;
        repeat (20) tick("en_low_mid_txn");
        req = 1'b0;
        tick("en_low_complete");

        // counter wrap over back-to-back handshakes
        do_reset("wrap_rst");
        enable    = 1'b1;
        cfg_delay = 4'd0;
        for (int k = 1; k <= 17; k++) begin
            req = 1'b1;
            tick("wrap_accept");
            tick("wrap_ack");
            req = 1'b0;
            tick("wrap_release");
            if (k == 15) check_eq("wrap_15", 32'(txn_count), 15);
            if (k == 16) check_eq("wrap_16", 32'(txn_count), 0);
            if (k == 17) check_eq("wrap_17", 32'(txn_count), 1);
        end

        // async reset while in ACK with req held; new transaction on first edge after release
        req = 1'b1;
        tick("ack_rst_accept");
        tick("ack_rst_ack");
        do_reset("ack_rst");
        tick("ack_rst_restart");
        check_eq("ack_rst_busy", 32'(busy), 1);
        req = 1'b0;
        tick("ack_rst_drop");

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = ~req;
            enable    = ($urandom_range(0, 7) != 0);
            cfg_delay = ($urandom_range(0, 9) == 0) ? DELAY_W'($urandom_range(0, 15))
                                                    : DELAY_W'($urandom_range(0, 3));
            if ($urandom_range(0, 399) == 0) do_reset("rnd_rst");
            tick("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
